// File: rtl/bfp_block_align.sv
// -----------------------------------------------------------------------------
// bfp_block_align
//
// Collects one V-element IEEE-754 single-precision vector arriving P lanes per
// beat, tracks the largest biased exponent seen, then replays the vector as
// P-lane beats of signed fixed-point mantissas aligned to that shared exponent.
//
// Optional feature macro: BFP_ROUND_EN
//   defined   -> round-to-nearest (ties up) with saturation at 2^MW-1
//   undefined -> pure truncation
//
// Parameters:
//   V    elements per vector (V % P == 0)
//   P    lanes per beat, in and out
//   BIT  input word width (IEEE-754 single, 32)
//   MW   mantissa magnitude bits, output lane width MW+1 (2..24)
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   valid_in    invals holds a beat (no backpressure from upstream)
//   invals      input lanes, lane i is element beat*P+i
//   last_in     final beat of the vector, sampled with valid_in
//   in_ready    high while collecting (informational)
//   valid_out   outvals/shared_exp hold an output beat
//   outvals     two's-complement aligned mantissas
//   shared_exp  biased block exponent
//   done        high with the final output beat
//   err         sticky: a beat arrived while emitting and was dropped
//
// Handshake: a beat transfers on any rising edge where valid_in is high and the
// block is collecting; valid_in while emitting is dropped and flags err. The
// output side has no ready: valid_out marks each of the V/P output beats, which
// are produced on consecutive cycles.
// -----------------------------------------------------------------------------
module bfp_block_align #(
    parameter int V   = 8,
    parameter int P   = 4,
    parameter int BIT = 32,
    parameter int MW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [P-1:0][BIT-1:0]  invals,
    input  logic                   last_in,
    output logic                   in_ready,
    output logic                   valid_out,
    output logic [P-1:0][MW:0]     outvals,
    output logic [7:0]             shared_exp,
    output logic                   done,
    output logic                   err
);

    localparam int NB = V / P;                       // beats per vector
    localparam int SW = (NB > 1) ? $clog2(NB) : 1;   // slot index width

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t                        state;
    logic [SW-1:0]                 cnt;
    logic [SW-1:0]                 out_cnt;
    logic [7:0]                    emax;
    logic [NB-1:0]                 slot_valid;
    logic [NB-1:0][P-1:0][BIT-1:0] buffer;

    logic [7:0]                    beat_emax;
    logic [P-1:0][MW:0]            beat_out;

    // Align one element to the block exponent. The total right shift applied to
    // the 24-bit significand is (24-MW) to drop to MW bits plus (emax-e) for
    // alignment; any total shift of 24 or more naturally yields zero.
    function automatic logic [MW:0] align_lane(input logic [BIT-1:0] w,
                                               input logic [7:0]     e_max);
        logic          s;
        logic [7:0]    e;
        logic [23:0]   sig;
        logic [8:0]    shamt;
        logic [MW-1:0] mag;
`ifdef BFP_ROUND_EN
        logic [24:0]   tmp;
`endif
        s     = w[31];
        e     = w[30:23];
        sig   = {1'b1, w[22:0]};
        shamt = {1'b0, e_max - e} + 9'(24 - MW);
`ifdef BFP_ROUND_EN
        // One guard bit below the kept field carries the first discarded bit.
        tmp = {sig, 1'b0} >> shamt;
        mag = MW'(tmp >> 1);
        if (tmp[0] && (mag != {MW{1'b1}}))
            mag = mag + 1'b1;
`else
        mag = MW'(sig >> shamt);
`endif
        if (e == 8'd0)
            mag = '0;                 // zero and denormals are flushed
        else if (e == 8'd255)
            mag = {MW{1'b1}};         // Inf/NaN saturate, sign kept
        align_lane = s ? -{1'b0, mag} : {1'b0, mag};
    endfunction

    // Running exponent maximum including the incoming beat. A zero exponent
    // can never raise the maximum, so zero/denormal lanes need no masking.
    always_comb begin
        beat_emax = emax;
        for (int i = 0; i < P; i++) begin
            if (invals[i][30:23] > beat_emax)
                beat_emax = invals[i][30:23];
        end
    end

    // Slots never written in this vector read as zero.
    always_comb begin
        beat_out = '0;
        for (int i = 0; i < P; i++) begin
            beat_out[i] = align_lane(slot_valid[out_cnt] ? buffer[out_cnt][i] : '0, emax);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= COLLECT;
            cnt        <= '0;
            out_cnt    <= '0;
            emax       <= '0;
            slot_valid <= '0;
            buffer     <= '0;
            in_ready   <= 1'b1;
            valid_out  <= 1'b0;
            outvals    <= '0;
            shared_exp <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    valid_out <= 1'b0;
                    done      <= 1'b0;
                    if (valid_in) begin
                        buffer[cnt]     <= invals;
                        slot_valid[cnt] <= 1'b1;
                        cnt             <= cnt + 1'b1;
                        emax            <= beat_emax;
                        if (last_in || (cnt == SW'(NB - 1))) begin
                            state    <= EMIT;
                            in_ready <= 1'b0;
                            out_cnt  <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (valid_in)
                        err <= 1'b1;
                    valid_out  <= 1'b1;
                    outvals    <= beat_out;
                    shared_exp <= emax;
                    if (out_cnt == SW'(NB - 1)) begin
                        done       <= 1'b1;
                        state      <= COLLECT;
                        in_ready   <= 1'b1;
                        emax       <= '0;
                        cnt        <= '0;
                        out_cnt    <= '0;
                        slot_valid <= '0;
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_bfp_block_align.sv
// -----------------------------------------------------------------------------
// tb_bfp_block_align
//
// Directed bench for bfp_block_align with V=8, P=4, MW=16. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge. Expected lane
// values are hand-computed constants queued in exp_q.
// -----------------------------------------------------------------------------
module tb_bfp_block_align;

    localparam int V   = 8;
    localparam int P   = 4;
    localparam int BIT = 32;
    localparam int MW  = 16;
    localparam int NB  = V / P;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic                  valid_in = 1'b0;
    logic                  last_in  = 1'b0;
    logic [P-1:0][BIT-1:0] invals   = '0;
    logic                  in_ready;
    logic                  valid_out;
    logic [P-1:0][MW:0]    outvals;
    logic [7:0]            shared_exp;
    logic                  done;
    logic                  err;

    bfp_block_align #(.V(V), .P(P), .BIT(BIT), .MW(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .invals     (invals),
        .last_in    (last_in),
        .in_ready   (in_ready),
        .valid_out  (valid_out),
        .outvals    (outvals),
        .shared_exp (shared_exp),
        .done       (done),
        .err        (err)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [MW:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [P-1:0][BIT-1:0] beat, input logic last);
        @(negedge clk);
        valid_in = 1'b1;
        last_in  = last;
        invals   = beat;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
        invals   = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (valid_out !== 1'b0) $display("FAIL reset valid_out: got %b want 0", valid_out); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else n_pass++;
        n_total++; if (outvals !== '0) $display("FAIL reset outvals: got %h want 0", outvals); else n_pass++;
        n_total++; if (shared_exp !== 8'd0) $display("FAIL reset shared_exp: got %0d want 0", shared_exp); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset err: got %b want 0", err); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
        reset = 1'b1;
    endtask

    // Three vectors back to back: uniform exponent, mixed exponents, early last_in.
    task automatic test_vectors();
        logic [P-1:0][BIT-1:0] w  [3][NB];
        logic [P-1:0][MW:0]    ex [3][NB];
        logic [7:0]            se [3];
        int                    nbeats [3];
        logic [MW:0]           e;

        // lanes listed MSB first: {lane3, lane2, lane1, lane0}
        w[0][0]  = {32'h3FF80000, 32'h3FF00000, 32'h3FE00000, 32'h3FC00000};
        w[0][1]  = w[0][0];
        ex[0][0] = {17'h0F800, 17'h0F000, 17'h0E000, 17'h0C000};
        ex[0][1] = ex[0][0];
        se[0] = 8'd127; nbeats[0] = 2;

        w[1][0]  = {32'h00000000, 32'hC0000000, 32'h3F800000, 32'h40800000};
        w[1][1]  = '0;
        ex[1][0] = {17'h00000, 17'h1C000, 17'h02000, 17'h08000};
        ex[1][1] = '0;
        se[1] = 8'd129; nbeats[1] = 2;

        w[2][0]  = {4{32'h3F800000}};
        w[2][1]  = '0;
        ex[2][0] = {4{17'h08000}};
        ex[2][1] = '0;
        se[2] = 8'd127; nbeats[2] = 1;

        for (int v = 0; v < 3; v++) begin
            for (int b = 0; b < nbeats[v]; b++)
                drive_beat(w[v][b], (b == nbeats[v] - 1));
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < P; i++)
                    exp_q.push_back(ex[v][b][i]);
            drive_idle();
            n_total++; if (in_ready !== 1'b0) $display("FAIL vec%0d in_ready after last: got %b want 0", v, in_ready); else n_pass++;
            n_total++; if (valid_out !== 1'b0) $display("FAIL vec%0d early valid_out: got %b want 0", v, valid_out); else n_pass++;
            for (int b = 0; b < NB; b++) begin
                @(negedge clk);
                n_total++; if (valid_out !== 1'b1) $display("FAIL vec%0d valid_out beat%0d: got %b want 1", v, b, valid_out); else n_pass++;
                n_total++; if (done !== (b == NB - 1)) $display("FAIL vec%0d done beat%0d: got %b want %b", v, b, done, (b == NB - 1)); else n_pass++;
                n_total++; if (shared_exp !== se[v]) $display("FAIL vec%0d shared_exp beat%0d: got %0d want %0d", v, b, shared_exp, se[v]); else n_pass++;
                for (int i = 0; i < P; i++) begin
                    e = exp_q.pop_front();
                    n_total++; if (outvals[i] !== e) $display("FAIL vec%0d lane%0d beat%0d: got %h want %h", v, i, b, outvals[i], e); else n_pass++;
                end
            end
            @(negedge clk);
            n_total++; if (valid_out !== 1'b0) $display("FAIL vec%0d valid_out after emit: got %b want 0", v, valid_out); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL vec%0d done after emit: got %b want 0", v, done); else n_pass++;
            n_total++; if (in_ready !== 1'b1) $display("FAIL vec%0d in_ready after emit: got %b want 1", v, in_ready); else n_pass++;
        end
    endtask

    // valid_in held high through EMIT with a large-exponent junk beat.
    task automatic test_drop();
        logic [P-1:0][BIT-1:0] beat;
        logic [P-1:0][MW:0]    ex;
        beat = {32'h3FF80000, 32'h3FF00000, 32'h3FE00000, 32'h3FC00000};
        ex   = {17'h0F800, 17'h0F000, 17'h0E000, 17'h0C000};
        drive_beat(beat, 1'b0);
        drive_beat(beat, 1'b1);
        @(negedge clk);
        invals  = {4{32'h7F000000}};
        last_in = 1'b1;
        n_total++; if (err !== 1'b0) $display("FAIL drop err before drop: got %b want 0", err); else n_pass++;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            if (b == NB - 1) begin
                valid_in = 1'b0;
                last_in  = 1'b0;
                invals   = '0;
            end
            n_total++; if (err !== 1'b1) $display("FAIL drop err beat%0d: got %b want 1", b, err); else n_pass++;
            n_total++; if (valid_out !== 1'b1) $display("FAIL drop valid_out beat%0d: got %b want 1", b, valid_out); else n_pass++;
            n_total++; if (shared_exp !== 8'd127) $display("FAIL drop shared_exp beat%0d: got %0d want 127", b, shared_exp); else n_pass++;
            n_total++; if (outvals !== ex) $display("FAIL drop outvals beat%0d: got %h want %h", b, outvals, ex); else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++; if (err !== 1'b1) $display("FAIL drop err sticky: got %b want 1", err); else n_pass++;
        n_total++; if (valid_out !== 1'b0) $display("FAIL drop stray valid_out: got %b want 0", valid_out); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL drop err after reset: got %b want 0", err); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // 0x3F800080: the first discarded bit is set.
    task automatic test_round();
        logic [MW:0] e;
`ifdef BFP_ROUND_EN
        e = 17'h08001;
`else
        e = 17'h08000;
`endif
        drive_beat({4{32'h3F800080}}, 1'b0);
        drive_beat({4{32'h3F800080}}, 1'b1);
        drive_idle();
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            n_total++; if (valid_out !== 1'b1) $display("FAIL round valid_out beat%0d: got %b want 1", b, valid_out); else n_pass++;
            for (int i = 0; i < P; i++) begin
                n_total++; if (outvals[i] !== e) $display("FAIL round lane%0d beat%0d: got %h want %h", i, b, outvals[i], e); else n_pass++;
            end
        end
        @(negedge clk);
    endtask

    // Reset during EMIT, then a fresh vector must use a fresh exponent maximum.
    task automatic test_reset_mid_emit();
        drive_beat({32'h00000000, 32'hC0000000, 32'h3F800000, 32'h40800000}, 1'b0);
        drive_beat('0, 1'b1);
        drive_idle();
        @(negedge clk);
        n_total++; if (valid_out !== 1'b1) $display("FAIL midrst valid_out before reset: got %b want 1", valid_out); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (valid_out !== 1'b0) $display("FAIL midrst valid_out: got %b want 0", valid_out); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL midrst done: got %b want 0", done); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (shared_exp !== 8'd0) $display("FAIL midrst shared_exp: got %0d want 0", shared_exp); else n_pass++;
        n_total++; if (outvals !== '0) $display("FAIL midrst outvals: got %h want 0", outvals); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        drive_beat({4{32'h3F800000}}, 1'b0);
        drive_beat({4{32'h3F800000}}, 1'b1);
        drive_idle();
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            n_total++; if (valid_out !== 1'b1) $display("FAIL midrst next valid_out beat%0d: got %b want 1", b, valid_out); else n_pass++;
            n_total++; if (shared_exp !== 8'd127) $display("FAIL midrst next shared_exp beat%0d: got %0d want 127", b, shared_exp); else n_pass++;
            n_total++; if (outvals !== {4{17'h08000}}) $display("FAIL midrst next outvals beat%0d: got %h want %h", b, outvals, {4{17'h08000}}); else n_pass++;
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_vectors();
        test_drop();
        test_round();
        test_reset_mid_emit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
